// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle DECODE/EXEC/MEM/WB control FSM for the mipscpu datapath
module instr_sequencer #(
    parameter int MEM_WAIT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        newinstr,
    input  logic [31:0] instrword,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        dropped,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [2:0]  aluop,
    output logic        alusrc,
    output logic        regdst,
    output logic        memtoreg,
    output logic        memread,
    output logic        memwrite,
    output logic        regwrite
);
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        nq_q;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        dropped_q, dropped_d;

    logic [5:0]  op, funct;
    logic        is_lw, is_sw, is_r, legal, start;
    logic [2:0]  r_aluop;
    logic [4:0]  dest;

    assign op    = ir_q[31:26];
    assign funct = ir_q[5:0];
    assign is_lw = op == 6'd35;
    assign is_sw = op == 6'd43;
    assign is_r  = op == 6'd0 && (funct == 6'd32 || funct == 6'd34 || funct == 6'd36 ||
                                  funct == 6'd37 || funct == 6'd42);
    assign legal = is_lw | is_sw | is_r;
    assign r_aluop = funct == 6'd32 ? 3'b010 :
                     funct == 6'd34 ? 3'b110 :
                     funct == 6'd36 ? 3'b000 :
                     funct == 6'd37 ? 3'b001 : 3'b111;
    assign dest  = is_r ? ir_q[15:11] : ir_q[20:16];
    assign start = newinstr & ~nq_q & (state_q == IDLE);

    // Next-state, instruction capture, MEM dwell counter and status pulses
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        dropped_d = newinstr & ~nq_q & (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    ir_d    = instrword;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d   = legal ? EXEC : IDLE;
                illegal_d = ~legal;
            end
            EXEC: begin
                cnt_d   = 4'd0;
                state_d = is_r ? WB : MEM;
            end
            MEM: begin
                if (cnt_q == 4'(MEM_WAIT - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = is_lw ? WB : IDLE;
                    done_d  = is_sw;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WB: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; nq resets high so a level held through reset is not an edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            cnt_q     <= '0;
            nq_q      <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            nq_q      <= newinstr;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            dropped_q <= dropped_d;
        end
    end

    // Datapath controls decoded from the registered state and instruction only
    always_comb begin
        busy     = state_q != IDLE;
        done     = done_q;
        illegal  = illegal_q;
        dropped  = dropped_q;
        rs       = ir_q[25:21];
        rt       = ir_q[20:16];
        rd       = ir_q[15:11];
        imm      = ir_q[15:0];
        aluop    = 3'b000;
        alusrc   = 1'b0;
        if (state_q == EXEC || state_q == MEM || state_q == WB) begin
            aluop  = is_r ? r_aluop : 3'b010;
            alusrc = ~is_r;
        end
        memread  = state_q == MEM && is_lw;
        memwrite = state_q == MEM && is_sw;
        regdst   = state_q == WB && is_r;
        memtoreg = state_q == WB && is_lw;
        regwrite = state_q == WB && dest != 5'd0;
    end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control sequencer for the `mipscpu` datapath. It accepts one instruction word per `newinstr` rising edge and decodes it. It then steps the datapath through DECODE, EXEC, MEM and WB states, driving the register-file, ALU and memory control strobes for each state. It sits between the instruction source (`instrword`/`newinstr`) and the datapath, and replaces ad-hoc per-instruction control with a single FSM.

## Interface
- `MEM_WAIT`, default 1: number of cycles the MEM state is held. Legal range is 1..15.

- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clock`
- `newinstr`  in  1  instruction strobe; a 0→1 transition sampled in IDLE starts an instruction
- `instrword`  in  32  instruction; captured on the start edge
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse in the first IDLE cycle after a legal instruction completes
- `illegal`  out  1  one-cycle pulse on an unsupported opcode/funct
- `dropped`  out  1  one-cycle pulse when a `newinstr` rising edge arrives while busy
- `rs`, `rt`, `rd`  out  5 each  latched register fields
- `imm`  out  16  latched immediate
- `aluop`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- `alusrc`  out  1  1 selects `imm`, 0 selects `rt`
- `regdst`  out  1  1 selects `rd` as write destination, 0 selects `rt`
- `memtoreg`  out  1  1 selects memory data for writeback
- `memread`, `memwrite`, `regwrite`  out  1 each  datapath strobes

## Operation
- Edge detect: `nq` is the registered copy of `newinstr`. `start = newinstr & ~nq & (state==IDLE)`.
- Reset sets `nq` to 1, so a level held high through reset does not start an instruction.
- On `start`, latch `instrword` into `ir`. Fields `rs`/`rt`/`rd`/`imm` are taken from `ir` and hold until the next `start`.
- Supported instructions:
  - op 35 (lw)
  - op 43 (sw)
  - op 0 with funct 32 (add), 34 (sub), 36 (and), 37 (or) or 42 (slt)
  - Everything else is illegal.
- FSM states are IDLE, DECODE, EXEC, MEM, WB. Transitions:
  - IDLE→DECODE on `start`.
  - DECODE→EXEC if legal. If illegal, DECODE→IDLE with `illegal` pulsed; `done` is not pulsed.
  - EXEC→MEM for lw/sw; EXEC→WB for R-type.
  - MEM holds for exactly `MEM_WAIT` cycles using an internal counter. It then goes to WB for lw, or IDLE for sw.
  - WB→IDLE.
- Control outputs by state:
  - `aluop`/`alusrc` are driven in EXEC, MEM and WB. lw/sw use add with `alusrc=1`; R-type uses the decoded op with `alusrc=0`. Both are 0 in IDLE and DECODE.
  - `memread` (lw) or `memwrite` (sw) is high for every MEM cycle.
  - In WB, `regwrite=1`, with `regdst=1` and `memtoreg=0` for R-type, or `regdst=0` and `memtoreg=1` for lw.
  - `regwrite` is suppressed (held 0) when the destination register is 0. WB is still visited.
  - `regdst`/`memtoreg` are 0 outside WB.
- All outputs are registered, i.e. a function of current state and `ir`. No output depends combinationally on `instrword` or `newinstr`.
- Reset, at any point including mid-instruction: on the next edge, state=IDLE, `ir`=0, all outputs 0, MEM counter 0, `nq`=1. Any partial MEM or WB is abandoned.

## Timing
- Cycle 0 is the edge that samples `start`.
- lw, `MEM_WAIT`=1: DECODE c1, EXEC c2, MEM c3, WB c4, IDLE with `done` c5.
- General latency from start to `done`:
  - lw: 4+`MEM_WAIT` cycles
  - sw: 3+`MEM_WAIT` cycles
  - R-type: 4 cycles (DECODE c1, EXEC c2, WB c3, `done` c4)
  - Illegal: `illegal` in c2, no `done`.
- The `done` cycle is IDLE, so a new rising edge sampled in that same cycle is accepted. Back-to-back throughput equals latency.
- A `newinstr` rising edge while busy pulses `dropped` on the next cycle and does not disturb `ir`, state or outputs.
- `busy` is high from c1 through the last non-IDLE state.

## Test plan
- lw $1,0($0): `instrword`=0x8C010000, pulse `newinstr` → c3 `memread`=1 with `aluop`=010, `alusrc`=1; c4 `regwrite`=1, `memtoreg`=1, `regdst`=0, `rt`=1; c5 `done`=1, `busy`=0.
- add $4,$1,$2: 0x00222020 → c2 `aluop`=010, `alusrc`=0; c3 `regwrite`=1, `regdst`=1, `rd`=4; c4 `done`. Repeat with sub $5,$4,$3 (0x00832822) → `aluop`=110, `rd`=5.
- sw $5,3($0): 0xAC050003 with `MEM_WAIT`=3 → `memwrite` high c3–c5, `imm`=3, `regwrite` never high, `done` c6.
- Illegal op 2: 0x08000000 → `illegal` pulse c2, no `done`, `busy` low c2. Also add with `rd`=0 (0x00220020) → WB visited with `regwrite`=0.
- Protocol: hold `newinstr` high for 10 cycles → exactly one instruction runs. Issue a second rising edge during EXEC → `dropped` pulse and the first instruction completes unchanged. Issue a rising edge in the `done` cycle → accepted.
- Assert `reset` during MEM of lw while holding `newinstr` high → next cycle all outputs 0 and state IDLE. No new start until `newinstr` falls and rises again.
